// File: rtl/return_addr_stack_if.sv
// Bus bundle for the return-address stack: push/pop/flush controls in, pop result and status out.
// CW must stay in step with the localparam of the same name in return_addr_stack.
interface return_addr_stack_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_data, pop, flush, clear_err,
    input  pop_data, pop_valid, top_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, flush, clear_err,
    output pop_data, pop_valid, top_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Return-address stack for the fetch stage: LIFO of link PCs with push+pop in one cycle,
// flush, sticky overflow/underflow flags and optional circular overwrite when full.
module return_addr_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  return_addr_stack_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_pop_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_top_data;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_replace;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  // r_ptr is the next free slot; wrap is explicit so non-power-of-2 depths work.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_ptr_inc  = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
  assign w_top_idx  = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - PW'(1);
  assign w_top_data = w_empty ? '0 : r_mem[w_top_idx];

  // Decode this cycle's operation; flush suppresses push/pop entirely.
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    w_replace = 1'b0;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (!bus.flush) begin
      if (bus.push && bus.pop) begin
        if (w_empty) begin
          w_unf_evt = 1'b1;
          w_do_push = 1'b1;
        end else begin
          w_replace = 1'b1;
        end
      end else if (bus.push) begin
        if (!w_full) begin
          w_do_push = 1'b1;
        end else begin
          w_ovf_evt = 1'b1;
          w_do_push = (WRAP_MODE != 0);
        end
      end else if (bus.pop) begin
        if (w_empty) w_unf_evt = 1'b1;
        else         w_do_pop  = 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push)      r_mem[r_ptr]     <= bus.push_data;
    else if (w_replace) r_mem[w_top_idx] <= bus.push_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= w_do_pop | w_replace;
      if (w_do_pop || w_replace) r_pop_data <= w_top_data;

      if (bus.flush) begin
        r_ptr   <= '0;
        r_count <= '0;
      end else if (w_do_push) begin
        r_ptr <= w_ptr_inc;
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_do_pop) begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - CW'(1);
      end

      // A new error event outranks a same-cycle clear.
      if (w_ovf_evt)          r_overflow  <= 1'b1;
      else if (bus.clear_err) r_overflow  <= 1'b0;
      if (w_unf_evt)          r_underflow <= 1'b1;
      else if (bus.clear_err) r_underflow <= 1'b0;
    end
  end

  assign bus.pop_data  = r_pop_data;
  assign bus.pop_valid = r_pop_valid;
  assign bus.top_data  = w_top_data;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: three instances cover reject mode, wrap mode and a
// non-power-of-2 depth; every expected value below is hand-derived.
module tb_return_addr_stack;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  return_addr_stack_if #(.WIDTH(32), .DEPTH(8)) if0 ();
  return_addr_stack_if #(.WIDTH(32), .DEPTH(8)) if1 ();
  return_addr_stack_if #(.WIDTH(32), .DEPTH(5)) if2 ();

  return_addr_stack #(.WIDTH(32), .DEPTH(8), .WRAP_MODE(0)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
  return_addr_stack #(.WIDTH(32), .DEPTH(8), .WRAP_MODE(1)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
  return_addr_stack #(.WIDTH(32), .DEPTH(5), .WRAP_MODE(0)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));

  task automatic idle();
    if0.push = 0; if0.push_data = '0; if0.pop = 0; if0.flush = 0; if0.clear_err = 0;
    if1.push = 0; if1.push_data = '0; if1.pop = 0; if1.flush = 0; if1.clear_err = 0;
    if2.push = 0; if2.push_data = '0; if2.pop = 0; if2.flush = 0; if2.clear_err = 0;
  endtask

  // Apply one cycle of stimulus to instance u, then sample 1 ns after the edge.
  task automatic drive(input int u, input logic pu, input logic [31:0] d, input logic po,
                       input logic fl, input logic ce);
    case (u)
      0: begin if0.push = pu; if0.push_data = d; if0.pop = po; if0.flush = fl; if0.clear_err = ce; end
      1: begin if1.push = pu; if1.push_data = d; if1.pop = po; if1.flush = fl; if1.clear_err = ce; end
      default: begin if2.push = pu; if2.push_data = d; if2.pop = po; if2.flush = fl; if2.clear_err = ce; end
    endcase
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    checks++; if (if0.count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", if0.count); end
    checks++; if (if0.empty !== 1'b1 || if0.full !== 1'b0) begin errors++; $display("FAIL rst_empty_full got %b%b exp 10", if0.empty, if0.full); end
    checks++; if (if0.pop_valid !== 1'b0 || if0.pop_data !== 32'h0) begin errors++; $display("FAIL rst_pop got v=%b d=%h exp v=0 d=0", if0.pop_valid, if0.pop_data); end
    checks++; if (if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", if0.overflow, if0.underflow); end
    checks++; if (if0.top_data !== 32'h0) begin errors++; $display("FAIL rst_top got %h exp 0", if0.top_data); end
  endtask

  task automatic test_lifo();
    logic [31:0] exp_pop [3];
    exp_pop[0] = 32'h30; exp_pop[1] = 32'h20; exp_pop[2] = 32'h10;
    drive(0, 1, 32'h10, 0, 0, 0);
    checks++; if (if0.top_data !== 32'h10 || if0.count !== 4'd1) begin errors++; $display("FAIL lifo_push1 got top=%h cnt=%0d exp 10/1", if0.top_data, if0.count); end
    drive(0, 1, 32'h20, 0, 0, 0);
    drive(0, 1, 32'h30, 0, 0, 0);
    checks++; if (if0.count !== 4'd3 || if0.pop_valid !== 1'b0) begin errors++; $display("FAIL lifo_cnt3 got cnt=%0d v=%b exp 3/0", if0.count, if0.pop_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 1, 0, 0);
      checks++;
      if (if0.pop_data !== exp_pop[i] || if0.pop_valid !== 1'b1 || if0.count !== 4'(2 - i)) begin
        errors++; $display("FAIL lifo_pop%0d got d=%h v=%b cnt=%0d exp d=%h v=1 cnt=%0d", i, if0.pop_data, if0.pop_valid, if0.count, exp_pop[i], 2 - i);
      end
    end
    drive(0, 0, 32'h0, 0, 0, 0);
    checks++; if (if0.pop_valid !== 1'b0 || if0.empty !== 1'b1) begin errors++; $display("FAIL lifo_after got v=%b e=%b exp 0/1", if0.pop_valid, if0.empty); end
    checks++; if (if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin errors++; $display("FAIL lifo_flags got %b%b exp 00", if0.overflow, if0.underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) drive(0, 1, 32'(i), 0, 0, 0);
    checks++; if (if0.full !== 1'b1 || if0.overflow !== 1'b0) begin errors++; $display("FAIL ovf_full got f=%b o=%b exp 1/0", if0.full, if0.overflow); end
    drive(0, 1, 32'h9, 0, 0, 0);
    checks++; if (if0.count !== 4'd8 || if0.overflow !== 1'b1 || if0.top_data !== 32'h8) begin errors++; $display("FAIL ovf_reject got cnt=%0d o=%b top=%h exp 8/1/8", if0.count, if0.overflow, if0.top_data); end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 32'h0, 1, 0, 0);
      checks++;
      if (if0.pop_data !== 32'(8 - i) || if0.pop_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d got d=%h v=%b exp d=%h v=1", i, if0.pop_data, if0.pop_valid, 8 - i);
      end
    end
    drive(0, 0, 32'h0, 1, 0, 0);
    checks++; if (if0.underflow !== 1'b1 || if0.pop_valid !== 1'b0 || if0.pop_data !== 32'h1) begin errors++; $display("FAIL unf_pop got u=%b v=%b d=%h exp 1/0/1", if0.underflow, if0.pop_valid, if0.pop_data); end
    drive(0, 0, 32'h0, 0, 0, 1);
    checks++; if (if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin errors++; $display("FAIL clear_err got %b%b exp 00", if0.overflow, if0.underflow); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 10; i++) drive(1, 1, 32'(i), 0, 0, 0);
    checks++; if (if1.count !== 4'd8 || if1.overflow !== 1'b1 || if1.top_data !== 32'hA) begin errors++; $display("FAIL wrap_fill got cnt=%0d o=%b top=%h exp 8/1/a", if1.count, if1.overflow, if1.top_data); end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 32'h0, 1, 0, 0);
      checks++;
      if (if1.pop_data !== 32'(10 - i) || if1.pop_valid !== 1'b1) begin
        errors++; $display("FAIL wrap_pop%0d got d=%h v=%b exp d=%h v=1", i, if1.pop_data, if1.pop_valid, 10 - i);
      end
    end
    checks++; if (if1.empty !== 1'b1 || if1.count !== 4'd0 || if1.underflow !== 1'b0) begin errors++; $display("FAIL wrap_empty got e=%b cnt=%0d u=%b exp 1/0/0", if1.empty, if1.count, if1.underflow); end
  endtask

  task automatic test_push_pop();
    drive(0, 1, 32'hA, 0, 0, 0);
    drive(0, 1, 32'hB, 0, 0, 0);
    drive(0, 1, 32'hC, 1, 0, 0);
    checks++; if (if0.pop_data !== 32'hB || if0.pop_valid !== 1'b1 || if0.count !== 4'd2 || if0.top_data !== 32'hC) begin
      errors++; $display("FAIL pp_replace got d=%h v=%b cnt=%0d top=%h exp b/1/2/c", if0.pop_data, if0.pop_valid, if0.count, if0.top_data); end
    drive(0, 0, 32'h0, 1, 0, 0);
    drive(0, 0, 32'h0, 1, 0, 0);
    checks++; if (if0.pop_data !== 32'hA || if0.empty !== 1'b1) begin errors++; $display("FAIL pp_drain got d=%h e=%b exp a/1", if0.pop_data, if0.empty); end
    drive(0, 1, 32'hD, 1, 0, 0);
    checks++; if (if0.underflow !== 1'b1 || if0.pop_valid !== 1'b0 || if0.count !== 4'd1 || if0.top_data !== 32'hD || if0.pop_data !== 32'hA) begin
      errors++; $display("FAIL pp_empty got u=%b v=%b cnt=%0d top=%h d=%h exp 1/0/1/d/a", if0.underflow, if0.pop_valid, if0.count, if0.top_data, if0.pop_data); end
    drive(0, 0, 32'h0, 0, 0, 1);
    for (int i = 1; i <= 7; i++) drive(0, 1, 32'h20 + 32'(i), 0, 0, 0);
    drive(0, 1, 32'h55, 1, 0, 0);
    checks++; if (if0.pop_data !== 32'h27 || if0.count !== 4'd8 || if0.top_data !== 32'h55 || if0.overflow !== 1'b0 || if0.full !== 1'b1) begin
      errors++; $display("FAIL pp_full got d=%h cnt=%0d top=%h o=%b f=%b exp 27/8/55/0/1", if0.pop_data, if0.count, if0.top_data, if0.overflow, if0.full); end
  endtask

  task automatic test_flush();
    drive(0, 0, 32'h0, 0, 1, 1);
    checks++; if (if0.count !== 4'd0 || if0.pop_valid !== 1'b0 || if0.underflow !== 1'b0) begin errors++; $display("FAIL fl_clean got cnt=%0d v=%b u=%b exp 0/0/0", if0.count, if0.pop_valid, if0.underflow); end
    drive(0, 0, 32'h0, 1, 0, 1);
    checks++; if (if0.underflow !== 1'b1) begin errors++; $display("FAIL fl_err_wins got u=%b exp 1", if0.underflow); end
    for (int i = 1; i <= 3; i++) drive(0, 1, 32'(i), 0, 0, 0);
    drive(0, 1, 32'hE, 1, 1, 0);
    checks++; if (if0.count !== 4'd0 || if0.pop_valid !== 1'b0 || if0.empty !== 1'b1 || if0.pop_data !== 32'h27) begin
      errors++; $display("FAIL fl_op got cnt=%0d v=%b e=%b d=%h exp 0/0/1/27", if0.count, if0.pop_valid, if0.empty, if0.pop_data); end
    checks++; if (if0.underflow !== 1'b1 || if0.overflow !== 1'b0) begin errors++; $display("FAIL fl_flags got o=%b u=%b exp 0/1", if0.overflow, if0.underflow); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) drive(2, 1, 32'(i), 0, 0, 0);
    drive(2, 1, 32'h9, 0, 0, 0);
    checks++; if (if2.count !== 3'd5 || if2.overflow !== 1'b1 || if2.top_data !== 32'h5) begin errors++; $display("FAIL d5_full got cnt=%0d o=%b top=%h exp 5/1/5", if2.count, if2.overflow, if2.top_data); end
    drive(2, 0, 32'h0, 1, 0, 0);
    drive(2, 1, 32'h6, 0, 0, 0);
    checks++; if (if2.top_data !== 32'h6 || if2.count !== 3'd5) begin errors++; $display("FAIL d5_wrap_top got top=%h cnt=%0d exp 6/5", if2.top_data, if2.count); end
    drive(2, 0, 32'h0, 1, 0, 0);
    checks++; if (if2.pop_data !== 32'h6 || if2.pop_valid !== 1'b1 || if2.count !== 3'd4) begin errors++; $display("FAIL d5_pop got d=%h v=%b cnt=%0d exp 6/1/4", if2.pop_data, if2.pop_valid, if2.count); end
    #3 rst = 1'b1;
    #1;
    checks++; if (if2.count !== 3'd0 || if2.pop_valid !== 1'b0 || if2.overflow !== 1'b0 || if2.empty !== 1'b1 || if2.pop_data !== 32'h0) begin
      errors++; $display("FAIL d5_async_rst got cnt=%0d v=%b o=%b e=%b d=%h exp 0/0/0/1/0", if2.count, if2.pop_valid, if2.overflow, if2.empty, if2.pop_data); end
    @(negedge clk);
    rst = 1'b0;
    drive(2, 1, 32'h7, 0, 0, 0);
    drive(2, 0, 32'h0, 1, 0, 0);
    checks++; if (if2.pop_data !== 32'h7 || if2.pop_valid !== 1'b1 || if2.count !== 3'd0) begin errors++; $display("FAIL d5_after_rst got d=%h v=%b cnt=%0d exp 7/1/0", if2.pop_data, if2.pop_valid, if2.count); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_lifo();
    test_overflow();
    test_wrap();
    test_push_pop();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
